// File: rtl/comp_seq_param_if.sv
// rtl/comp_seq_param_if.sv - request/result bundle for the digit-serial comparator
//
// Purpose : groups the comparison request (start, signed_mode, A, B) and the
//           result/status signals (busy, done, G, E, L) of comp_seq_param.
// Signals : start        request a comparison (sampled only while idle)
//           signed_mode  1 = two's-complement compare, 0 = unsigned
//           A, B         WIDTH-bit operands, sampled together with start
//           busy         high while the compare is running
//           done         one-cycle pulse marking a new result
//           G, E, L      registered one-hot result: A>B, A==B, A<B
// Modports: master drives the request, slave is the comparator.
interface comp_seq_param_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             G;
   logic             E;
   logic             L;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, G, E, L
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, G, E, L
   );
endinterface

// File: rtl/comp_seq_param.sv
// rtl/comp_seq_param.sv - digit-serial magnitude comparator, MSB digit first
//
// Purpose : compares two WIDTH-bit operands DIGIT bits per cycle starting at
//           the most significant digit and stops at the first differing
//           digit (or after the last digit when all are equal).
// Ports   : clk  single clock, rising edge
//           rst  synchronous active-high reset
//           bus  comp_seq_param_if slave modport (start, signed_mode, A, B in;
//                busy, done, G, E, L out)
// Params  : WIDTH operand width (2..64), DIGIT bits per cycle, WIDTH % DIGIT == 0
module comp_seq_param #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   comp_seq_param_if.slave bus
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_g;
   logic             r_e;
   logic             r_l;

   logic [DIGIT-1:0] w_da;
   logic [DIGIT-1:0] w_db;
   logic             w_diff;
   logic             w_last;
   logic [WIDTH-1:0] w_flip;

   // Top digit of each shift register is the one under comparison.
   assign w_da   = r_a[WIDTH-1 -: DIGIT];
   assign w_db   = r_b[WIDTH-1 -: DIGIT];
   assign w_diff = (w_da != w_db);
   assign w_last = (r_cnt == CW'(N - 1));

   // Inverting the sign bit maps two's-complement order onto unsigned order,
   // so the datapath only ever needs an unsigned compare.
   assign w_flip = bus.signed_mode ? MSB_MASK : '0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = RUN;
         RUN:     if (w_diff || w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_g     <= 1'b0;
         r_e     <= 1'b0;
         r_l     <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a   <= bus.A ^ w_flip;
                  r_b   <= bus.B ^ w_flip;
                  r_cnt <= '0;
               end
            end
            RUN: begin
               if (w_diff) begin
                  r_g <= (w_da > w_db);
                  r_e <= 1'b0;
                  r_l <= (w_da < w_db);
               end else if (w_last) begin
                  r_g <= 1'b0;
                  r_e <= 1'b1;
                  r_l <= 1'b0;
               end else begin
                  r_a   <= r_a << DIGIT;
                  r_b   <= r_b << DIGIT;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state == RUN);
   assign bus.done = (r_state == DONE);
   assign bus.G    = r_g;
   assign bus.E    = r_e;
   assign bus.L    = r_l;

endmodule

// File: tb/tb_comp_seq_param.sv
// tb/tb_comp_seq_param.sv - scoreboard bench for comp_seq_param at DIGIT 1, 2 and 4
module tb_comp_seq_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       smode = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;

   int checks = 0;
   int errors = 0;
   int dcnt [3];

   logic [2:0] q0 [$];
   logic [2:0] q1 [$];
   logic [2:0] q2 [$];

   always #5 clk = ~clk;

   comp_seq_param_if #(.WIDTH(8)) if1 ();
   comp_seq_param_if #(.WIDTH(8)) if2 ();
   comp_seq_param_if #(.WIDTH(8)) if4 ();

   assign if1.start = start;  assign if1.signed_mode = smode;
   assign if1.A     = a_in;   assign if1.B           = b_in;
   assign if2.start = start;  assign if2.signed_mode = smode;
   assign if2.A     = a_in;   assign if2.B           = b_in;
   assign if4.start = start;  assign if4.signed_mode = smode;
   assign if4.A     = a_in;   assign if4.B           = b_in;

   comp_seq_param #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   comp_seq_param #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   comp_seq_param #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   logic       w_done [3];
   logic [2:0] w_gel  [3];
   assign w_done[0] = if1.done;  assign w_gel[0] = {if1.G, if1.E, if1.L};
   assign w_done[1] = if2.done;  assign w_gel[1] = {if2.G, if2.E, if2.L};
   assign w_done[2] = if4.done;  assign w_gel[2] = {if4.G, if4.E, if4.L};

   initial begin
      for (int k = 0; k < 3; k++) dcnt[k] = 0;
   end

   // Scoreboard monitor: every done pulse pops one expected {G,E,L}.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (w_done[k] === 1'b1) begin
            logic [2:0] exp_v;
            int         qs;
            dcnt[k] = dcnt[k] + 1;
            qs = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
            checks++;
            if (qs == 0) begin
               errors++;
               $display("FAIL sb_unexpected_done inst%0d: got done with empty scoreboard, want no done", k);
            end else begin
               case (k)
                  0:       exp_v = q0.pop_front();
                  1:       exp_v = q1.pop_front();
                  default: exp_v = q2.pop_front();
               endcase
               if (w_gel[k] !== exp_v) begin
                  errors++;
                  $display("FAIL sb_gel inst%0d: got GEL=%b want %b", k, w_gel[k], exp_v);
               end
            end
         end
      end
   end

   function automatic logic [2:0] ref_gel(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic signed [8:0] sa;
      logic signed [8:0] sb;
      sa = m ? $signed({a[7], a}) : $signed({1'b0, a});
      sb = m ? $signed({b[7], b}) : $signed({1'b0, b});
      if (sa > sb)       return 3'b100;
      else if (sa == sb) return 3'b010;
      else               return 3'b001;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request to all three instances; edges are counted with the start
   // sampling edge as edge 1. Operands are scrambled right after capture.
   task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic m,
                         input bit extra_start,
                         output int lat1, output int lat2, output int bsy1,
                         output int bsy2, output int nd1, output int nd2);
      logic [2:0] e;
      int         edges;
      bit         fin;
      e = ref_gel(a, b, m);
      q0.push_back(e);
      q1.push_back(e);
      q2.push_back(e);
      a_in = a; b_in = b; smode = m; start = 1'b1;
      lat1 = 0; lat2 = 0; bsy1 = 0; bsy2 = 0; nd1 = 0; nd2 = 0;
      edges = 0; fin = 1'b0;
      while (!fin && edges < 30) begin
         step();
         edges++;
         if (edges == 1) begin
            start = extra_start;
            a_in  = ~a; b_in = ~b; smode = ~m;
         end else begin
            start = 1'b0;
         end
         if (if1.done && lat1 == 0) lat1 = edges;
         if (if2.done && lat2 == 0) lat2 = edges;
         bsy1 += int'(if1.busy);
         bsy2 += int'(if2.busy);
         nd1  += int'(if1.done);
         nd2  += int'(if2.done);
         if (edges > 1 && !(if1.busy || if1.done || if2.busy || if2.done || if4.busy || if4.done))
            fin = 1'b1;
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL txn_timeout: got no return to idle after %0d edges, want idle", edges);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({if1.busy, if1.done, if1.G, if1.E, if1.L} !== 5'b0) begin
         errors++;
         $display("FAIL reset_d1: got %b want 00000", {if1.busy, if1.done, if1.G, if1.E, if1.L});
      end
      checks++;
      if ({if2.busy, if2.done, if2.G, if2.E, if2.L} !== 5'b0) begin
         errors++;
         $display("FAIL reset_d2: got %b want 00000", {if2.busy, if2.done, if2.G, if2.E, if2.L});
      end
      checks++;
      if ({if4.busy, if4.done, if4.G, if4.E, if4.L} !== 5'b0) begin
         errors++;
         $display("FAIL reset_d4: got %b want 00000", {if4.busy, if4.done, if4.G, if4.E, if4.L});
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_greater();
      int l1, l2, b1, b2, n1, n2;
      do_txn(8'h80, 8'h00, 1'b0, 1'b0, l1, l2, b1, b2, n1, n2);
      checks++;
      if (l1 != 2) begin errors++; $display("FAIL gt_latency_d1: got %0d want 2", l1); end
      checks++;
      if (b1 != 1) begin errors++; $display("FAIL gt_busy_d1: got %0d want 1", b1); end
      checks++;
      if (l2 != 2) begin errors++; $display("FAIL gt_latency_d2: got %0d want 2", l2); end
      checks++;
      if ({if1.G, if1.E, if1.L} !== 3'b100) begin
         errors++; $display("FAIL gt_hold_d1: got %b want 100", {if1.G, if1.E, if1.L});
      end
   endtask

   task automatic test_equal();
      int l1, l2, b1, b2, n1, n2;
      do_txn(8'h5A, 8'h5A, 1'b0, 1'b0, l1, l2, b1, b2, n1, n2);
      checks++;
      if (l1 != 9) begin errors++; $display("FAIL eq_latency_d1: got %0d want 9", l1); end
      checks++;
      if (b1 != 8) begin errors++; $display("FAIL eq_busy_d1: got %0d want 8", b1); end
      checks++;
      if (l2 != 5) begin errors++; $display("FAIL eq_latency_d2: got %0d want 5", l2); end
      checks++;
      if (n1 != 1) begin errors++; $display("FAIL eq_done_width_d1: got %0d want 1", n1); end
   endtask

   task automatic test_signed();
      int l1, l2, b1, b2, n1, n2;
      do_txn(8'hFF, 8'h01, 1'b0, 1'b0, l1, l2, b1, b2, n1, n2);
      checks++;
      if (l1 != 2) begin errors++; $display("FAIL uns_latency_d1: got %0d want 2", l1); end
      checks++;
      if ({if1.G, if1.E, if1.L} !== 3'b100) begin
         errors++; $display("FAIL uns_hold_d1: got %b want 100", {if1.G, if1.E, if1.L});
      end
      do_txn(8'hFF, 8'h01, 1'b1, 1'b0, l1, l2, b1, b2, n1, n2);
      checks++;
      if (l1 != 2) begin errors++; $display("FAIL sgn_latency_d1: got %0d want 2", l1); end
      checks++;
      if ({if1.G, if1.E, if1.L} !== 3'b001) begin
         errors++; $display("FAIL sgn_hold_d1: got %b want 001", {if1.G, if1.E, if1.L});
      end
   endtask

   task automatic test_back_to_back_ignore();
      int l1, l2, b1, b2, n1, n2;
      do_txn(8'h0B, 8'h0A, 1'b0, 1'b1, l1, l2, b1, b2, n1, n2);
      checks++;
      if (l2 != 5) begin errors++; $display("FAIL ign_latency_d2: got %0d want 5", l2); end
      checks++;
      if (n2 != 1) begin errors++; $display("FAIL ign_done_count_d2: got %0d want 1", n2); end
      checks++;
      if (n1 != 1) begin errors++; $display("FAIL ign_done_count_d1: got %0d want 1", n1); end
      checks++;
      if (l1 != 9) begin errors++; $display("FAIL ign_latency_d1: got %0d want 9", l1); end
      checks++;
      if ({if2.G, if2.E, if2.L} !== 3'b100) begin
         errors++; $display("FAIL ign_hold_d2: got %b want 100", {if2.G, if2.E, if2.L});
      end
   endtask

   task automatic test_reset_abort();
      int seen1, seen2;
      int l1, l2, b1, b2, n1, n2;
      // DIGIT=4 finishes on edge 3, before the abort lands on edge 4.
      q2.push_back(3'b010);
      seen1 = 0; seen2 = 0;
      a_in = 8'h01; b_in = 8'h01; smode = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      seen1 += int'(if1.done); seen2 += int'(if2.done);
      step();
      seen1 += int'(if1.done); seen2 += int'(if2.done);
      step();
      seen1 += int'(if1.done); seen2 += int'(if2.done);
      rst = 1'b1;
      step();
      seen1 += int'(if1.done); seen2 += int'(if2.done);
      checks++;
      if (seen1 != 0) begin errors++; $display("FAIL abort_no_done_d1: got %0d want 0", seen1); end
      checks++;
      if (seen2 != 0) begin errors++; $display("FAIL abort_no_done_d2: got %0d want 0", seen2); end
      checks++;
      if ({if1.busy, if1.done, if1.G, if1.E, if1.L} !== 5'b0) begin
         errors++; $display("FAIL abort_outputs_d1: got %b want 00000", {if1.busy, if1.done, if1.G, if1.E, if1.L});
      end
      checks++;
      if ({if4.busy, if4.done, if4.G, if4.E, if4.L} !== 5'b0) begin
         errors++; $display("FAIL abort_outputs_d4: got %b want 00000", {if4.busy, if4.done, if4.G, if4.E, if4.L});
      end
      rst = 1'b0;
      step();
      checks++;
      if ({if1.busy, if1.done} !== 2'b00) begin
         errors++; $display("FAIL abort_idle_d1: got %b want 00", {if1.busy, if1.done});
      end
      do_txn(8'h02, 8'h03, 1'b0, 1'b0, l1, l2, b1, b2, n1, n2);
      checks++;
      if ({if1.G, if1.E, if1.L} !== 3'b001) begin
         errors++; $display("FAIL post_abort_hold_d1: got %b want 001", {if1.G, if1.E, if1.L});
      end
      checks++;
      if (l1 != 9) begin errors++; $display("FAIL post_abort_latency_d1: got %0d want 9", l1); end
   endtask

   task automatic test_random();
      int base [3];
      int l1, l2, b1, b2, n1, n2;
      logic [7:0] ra, rb;
      logic       rm;
      for (int k = 0; k < 3; k++) base[k] = dcnt[k];
      for (int t = 0; t < 1000; t++) begin
         ra = 8'($urandom);
         rb = (t % 8 == 0) ? ra : 8'($urandom);
         rm = 1'($urandom_range(0, 1));
         do_txn(ra, rb, rm, 1'b0, l1, l2, b1, b2, n1, n2);
      end
      step();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dcnt[k] - base[k] != 1000) begin
            errors++; $display("FAIL rand_done_count inst%0d: got %0d want 1000", k, dcnt[k] - base[k]);
         end
      end
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++; $display("FAIL rand_sb_empty: got %0d pending want 0", q0.size() + q1.size() + q2.size());
      end
   endtask

   initial begin
      test_reset();
      test_greater();
      test_equal();
      test_signed();
      test_back_to_back_ignore();
      test_reset_abort();
      test_random();
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/comp_seq_param.md
COMP_SEQ_PARAM -- requirements
Module: comp_seq_param

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 1, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a comparison; sampled only in IDLE.
REQ-006 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 A  input  WIDTH  first operand; sampled with start.
REQ-008 B  input  WIDTH  second operand; sampled with start.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  one-cycle pulse marking a valid new result.
REQ-011 G  output  1  A > B for the last completed comparison.
REQ-012 E  output  1  A == B for the last completed comparison.
REQ-013 L  output  1  A < B for the last completed comparison.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at a rising edge SHALL latch A and B into internal shift registers, clear the digit counter, and go to RUN.
REQ-016 In signed mode, the MSB of both latched operands SHALL be inverted at capture, so the unsigned compare that follows yields the signed result.
REQ-017 Each RUN cycle SHALL compare the top DIGIT bits of both shift registers as unsigned values.
REQ-018 If the top digits differ, the block SHALL write G/E/L (G=1 if A's digit is larger, else L=1; E=0) and go to DONE.
REQ-019 If the top digits are equal and the counter is below N-1, both registers SHALL shift left by DIGIT, the counter SHALL increment, and the state SHALL stay RUN.
REQ-020 If the top digits are equal and the counter equals N-1, the block SHALL write G=0, E=1, L=0 and go to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-023 G, E and L SHALL be registered, SHALL be one-hot once written, and SHALL hold until the next DONE or until reset.
REQ-024 Latency: for a decision on digit i (0 = most significant), done SHALL be high in the cycle after the (i+2)-th rising edge counted from the edge that samples start; worst case is N+1 edges.
REQ-025 start in RUN or DONE SHALL be ignored, with no queuing; a new request is accepted only in IDLE, so the minimum start-to-start spacing is 3 cycles.
REQ-026 Changes on A, B or signed_mode after capture SHALL NOT affect the comparison in progress.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, G=0, E=0, L=0, and clear the counter and shift registers.
REQ-028 rst SHALL take priority over start and over any in-flight comparison; the aborted operation SHALL produce no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, DIGIT=1, unsigned: A=0x80, B=0x00 -> done 2 edges after start, G=1 E=0 L=0, busy high for 1 cycle.
REQ-031 WIDTH=8, DIGIT=1, unsigned: A=0x5A, B=0x5A -> done 9 edges after start, E=1 G=0 L=0, busy high for 8 cycles.
REQ-032 WIDTH=8, DIGIT=1: A=0xFF, B=0x01 -> unsigned gives G=1 after 2 edges; signed gives L=1 (-1 < 1) after 2 edges.
REQ-033 WIDTH=8, DIGIT=2, unsigned: A=0x0B, B=0x0A -> decision on digit 3, done 5 edges after start, G=1; start pulsed during RUN is ignored, and exactly one done pulse occurs.
REQ-034 WIDTH=8, DIGIT=1: start with A=0x01, B=0x01, rst asserted on the 3rd RUN cycle -> no done pulse, all outputs 0, IDLE; next start with A=0x02, B=0x03 -> L=1.
REQ-035 Randomized check: 1000 random A/B/mode/WIDTH=8 transactions at DIGIT=1, 2 and 4 SHALL match a reference compare, with done exactly once per accepted start.
